// File: rtl/atm_keypad_entry.sv
`default_nettype none
// ============================================================================
//  Module   : atm_keypad_entry
//  Purpose  : Turns single-key strobes into PIN digits, a binary amount and
//             OKAY/CANCEL pulses for the downstream ATM transaction FSM.
//  Revision : 1.0  initial release
// ============================================================================
module atm_keypad_entry #(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int AMOUNT_DIGITS  = 9
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        KEY_VALID,
    input  logic [3:0]  KEY_CODE,
    input  logic        MODE,
    output logic [3:0]  PIN0,
    output logic [3:0]  PIN1,
    output logic [3:0]  PIN2,
    output logic [3:0]  PIN3,
    output logic [31:0] AMOUNT,
    output logic [3:0]  DIGIT_COUNT,
    output logic        OKAY,
    output logic        CANCEL
);

    localparam logic [1:0]  S_EMPTY      = 2'd0;
    localparam logic [1:0]  S_ENTRY      = 2'd1;
    localparam logic [1:0]  S_DONE       = 2'd2;
    localparam logic [3:0]  C_KEY_CLEAR  = 4'hA;
    localparam logic [3:0]  C_KEY_ENTER  = 4'hB;
    localparam logic [3:0]  C_KEY_CANCEL = 4'hC;
    localparam logic [3:0]  C_PIN_LEN    = 4'd4;
    localparam logic [3:0]  C_AMT_MAX    = 4'(AMOUNT_DIGITS);
    localparam logic [31:0] C_IDLE_LAST  = 32'(TIMEOUT_CYCLES - 1);

    logic [1:0]  r_state;
    logic        r_mode_q;
    logic [3:0]  r_pin [4];
    logic [31:0] r_amount;
    logic [3:0]  r_count;
    logic        r_okay;
    logic        r_cancel;
    logic [31:0] r_idle_cnt;

    logic        w_mode_chg;
    logic        w_key;
    logic        w_is_digit;
    logic        w_timeout;
    logic        w_clear;
    logic        w_store;
    logic        w_room;
    logic [3:0]  w_base_count;
    logic [31:0] w_base_amount;
    logic [31:0] w_amount_next;

    assign w_mode_chg = (MODE != r_mode_q);
    assign w_key      = KEY_VALID && !w_mode_chg;
    assign w_is_digit = (KEY_CODE <= 4'd9);
    assign w_timeout  = !w_mode_chg && !KEY_VALID && (r_state == S_ENTRY) &&
                        (r_idle_cnt == C_IDLE_LAST);

    // A digit in DONE starts a fresh entry, so it builds on a cleared buffer.
    assign w_base_count  = (r_state == S_DONE) ? 4'd0  : r_count;
    assign w_base_amount = (r_state == S_DONE) ? 32'd0 : r_amount;
    assign w_amount_next = w_base_amount * 32'd10 + {28'd0, KEY_CODE};
    assign w_room        = r_mode_q ? (w_base_count < C_AMT_MAX)
                                    : (w_base_count < C_PIN_LEN);

    assign w_clear = w_mode_chg || w_timeout ||
                     (w_key && (r_state != S_EMPTY) &&
                      ((KEY_CODE == C_KEY_CLEAR) || (KEY_CODE == C_KEY_CANCEL) ||
                       (w_is_digit && (r_state == S_DONE))));
    assign w_store = w_key && w_is_digit && w_room;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state    <= S_EMPTY;
            r_mode_q   <= 1'b0;
            for (int i = 0; i < 4; i++) r_pin[i] <= 4'd0;
            r_amount   <= 32'd0;
            r_count    <= 4'd0;
            r_okay     <= 1'b0;
            r_cancel   <= 1'b0;
            r_idle_cnt <= 32'd0;
        end else begin
            r_okay   <= 1'b0;
            r_cancel <= 1'b0;

            if (w_clear) begin
                for (int i = 0; i < 4; i++) r_pin[i] <= 4'd0;
                r_amount <= 32'd0;
                r_count  <= 4'd0;
            end
            if (w_store) begin
                if (r_mode_q) r_amount <= w_amount_next;
                else          r_pin[w_base_count[1:0]] <= KEY_CODE;
                r_count <= w_base_count + 4'd1;
            end

            if (w_mode_chg || KEY_VALID || (r_state != S_ENTRY) || w_timeout)
                r_idle_cnt <= 32'd0;
            else
                r_idle_cnt <= r_idle_cnt + 32'd1;

            if (w_mode_chg) begin
                r_mode_q <= MODE;
                r_state  <= S_EMPTY;
            end else if (KEY_VALID) begin
                case (r_state)
                    S_EMPTY: begin
                        if (w_is_digit)                    r_state  <= S_ENTRY;
                        else if (KEY_CODE == C_KEY_CANCEL) r_cancel <= 1'b1;
                    end
                    S_ENTRY: begin
                        if (KEY_CODE == C_KEY_CLEAR) begin
                            r_state <= S_EMPTY;
                        end else if (KEY_CODE == C_KEY_CANCEL) begin
                            r_cancel <= 1'b1;
                            r_state  <= S_EMPTY;
                        end else if ((KEY_CODE == C_KEY_ENTER) &&
                                     (r_mode_q || (r_count == C_PIN_LEN))) begin
                            r_okay  <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                    S_DONE: begin
                        if (w_is_digit) begin
                            r_state <= S_ENTRY;
                        end else if (KEY_CODE == C_KEY_ENTER) begin
                            r_okay <= 1'b1;
                        end else if (KEY_CODE == C_KEY_CANCEL) begin
                            r_cancel <= 1'b1;
                            r_state  <= S_EMPTY;
                        end else if (KEY_CODE == C_KEY_CLEAR) begin
                            r_state <= S_EMPTY;
                        end
                    end
                    default: r_state <= S_EMPTY;
                endcase
            end else if (w_timeout) begin
                r_cancel <= 1'b1;
                r_state  <= S_EMPTY;
            end
        end
    end

    assign PIN0        = r_pin[0];
    assign PIN1        = r_pin[1];
    assign PIN2        = r_pin[2];
    assign PIN3        = r_pin[3];
    assign AMOUNT      = r_amount;
    assign DIGIT_COUNT = r_count;
    assign OKAY        = r_okay;
    assign CANCEL      = r_cancel;

endmodule
`default_nettype wire

// File: tb/tb_atm_keypad_entry.sv
`default_nettype none
// ============================================================================
//  Module   : tb_atm_keypad_entry
//  Purpose  : Directed plus randomized key streams against a digit-list model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_atm_keypad_entry;

    localparam int TO = 8;
    localparam int AD = 9;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        KEY_VALID;
    logic [3:0]  KEY_CODE;
    logic        MODE;
    logic [3:0]  PIN0, PIN1, PIN2, PIN3;
    logic [31:0] AMOUNT;
    logic [3:0]  DIGIT_COUNT;
    logic        OKAY, CANCEL;

    atm_keypad_entry #(.TIMEOUT_CYCLES(TO), .AMOUNT_DIGITS(AD)) dut (
        .CLK(CLK), .RESET(RESET), .KEY_VALID(KEY_VALID), .KEY_CODE(KEY_CODE),
        .MODE(MODE), .PIN0(PIN0), .PIN1(PIN1), .PIN2(PIN2), .PIN3(PIN3),
        .AMOUNT(AMOUNT), .DIGIT_COUNT(DIGIT_COUNT), .OKAY(OKAY), .CANCEL(CANCEL)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: the entry is just the list of accepted digits plus an "accepted" flag.
    int q[$];
    bit m_done;
    bit m_mode;
    int m_idle;
    bit e_okay;
    bit e_cancel;
    bit cur_mode;

    task automatic chk(string name, longint act, longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_step(bit rst, bit mode, bit kv, logic [3:0] kc);
        int limit;
        e_okay   = 0;
        e_cancel = 0;
        if (rst) begin
            q.delete(); m_done = 0; m_mode = 0; m_idle = 0;
        end else if (mode != m_mode) begin
            q.delete(); m_done = 0; m_mode = mode; m_idle = 0;
        end else if (kv) begin
            limit  = m_mode ? AD : 4;
            m_idle = 0;
            if (kc <= 9) begin
                if (m_done) begin q.delete(); m_done = 0; end
                if (q.size() < limit) q.push_back(int'(kc));
            end else if (kc == 4'hA) begin
                q.delete(); m_done = 0;
            end else if (kc == 4'hC) begin
                q.delete(); m_done = 0; e_cancel = 1;
            end else if (kc == 4'hB) begin
                if (m_done) e_okay = 1;
                else if (q.size() > 0 && (m_mode || q.size() == 4)) begin
                    e_okay = 1; m_done = 1;
                end
            end
        end else if (q.size() > 0 && !m_done) begin
            if (m_idle == TO - 1) begin
                q.delete(); e_cancel = 1; m_idle = 0;
            end else begin
                m_idle++;
            end
        end else begin
            m_idle = 0;
        end
    endtask

    task automatic compare();
        longint amt;
        int     ep [4];
        amt = 0;
        for (int i = 0; i < 4; i++)
            ep[i] = (!m_mode && i < q.size()) ? q[i] : 0;
        if (m_mode) foreach (q[i]) amt = amt * 10 + q[i];
        chk("PIN0", PIN0, ep[0]);
        chk("PIN1", PIN1, ep[1]);
        chk("PIN2", PIN2, ep[2]);
        chk("PIN3", PIN3, ep[3]);
        chk("AMOUNT", AMOUNT, amt);
        chk("DIGIT_COUNT", DIGIT_COUNT, q.size());
        chk("OKAY", OKAY, e_okay);
        chk("CANCEL", CANCEL, e_cancel);
        chk("OKAY_CANCEL_EXCL", OKAY & CANCEL, 0);
    endtask

    task automatic cycle(bit rst, bit mode, bit kv, logic [3:0] kc);
        RESET = rst; MODE = mode; KEY_VALID = kv; KEY_CODE = kc;
        @(posedge CLK);
        #1;
        model_step(rst, mode, kv, kc);
        compare();
    endtask

    task automatic key(logic [3:0] k);
        cycle(1'b0, cur_mode, 1'b1, k);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) cycle(1'b0, cur_mode, 1'b0, 4'h0);
    endtask

    initial begin
        logic [3:0] kc;
        int         dens;
        RESET = 1; MODE = 0; KEY_VALID = 0; KEY_CODE = 0;
        cur_mode = 0;
        cycle(1, 0, 0, 0);
        cycle(1, 0, 1, 4'd5);
        chk("reset_count_lit", DIGIT_COUNT, 0);
        chk("reset_amount_lit", AMOUNT, 0);

        // PIN entry
        key(3); key(7); key(1); key(9);
        chk("pin_count_lit", DIGIT_COUNT, 4);
        key(4'hB);
        chk("pin_okay_lit", OKAY, 1);
        chk("pin_value_lit", {PIN0, PIN1, PIN2, PIN3}, 16'h3719);
        idle(1);
        chk("pin_okay_drop_lit", OKAY, 0);
        key(4'hB);
        chk("done_ack_lit", OKAY, 1);
        chk("done_ack_pin_lit", {PIN0, PIN1, PIN2, PIN3}, 16'h3719);
        key(2);
        chk("done_digit_lit", {PIN0, PIN1, PIN2, PIN3, DIGIT_COUNT}, 20'h20001);

        // Short PIN, then extra digit dropped
        key(4'hA);
        key(5); key(5); key(4'hB);
        chk("short_no_okay_lit", OKAY, 0);
        chk("short_count_lit", DIGIT_COUNT, 2);
        key(1); key(2); key(8); key(4'hB);
        chk("overflow_pin_lit", {PIN0, PIN1, PIN2, PIN3}, 16'h5512);
        chk("overflow_okay_lit", OKAY, 1);

        // Cancel and clear
        key(4'hA); key(4); key(4'hC);
        chk("cancel_pulse_lit", CANCEL, 1);
        chk("cancel_clear_lit", PIN0, 0);
        key(6); key(4'hA);
        chk("clear_no_pulse_lit", CANCEL, 0);

        // Mode change with a digit in the same cycle
        key(3);
        cur_mode = 1;
        key(4);
        chk("modechg_count_lit", DIGIT_COUNT, 0);
        key(1); key(2); key(5); key(0); key(4'hB);
        chk("amount_lit", AMOUNT, 1250);
        chk("amount_okay_lit", OKAY, 1);
        key(4'hA);
        key(4); key(2); key(9); key(4); key(9); key(6); key(7); key(2); key(9); key(5);
        key(4'hB);
        chk("amount_max_lit", AMOUNT, 429496729);
        chk("amount_max_count_lit", DIGIT_COUNT, 9);

        // Timeout
        cur_mode = 0;
        idle(1);
        key(6); idle(TO - 1);
        chk("timeout_early_lit", CANCEL, 0);
        idle(1);
        chk("timeout_pulse_lit", CANCEL, 1);
        key(6); idle(TO - 2); key(5); idle(TO - 1);
        chk("timeout_restart_lit", CANCEL, 0);
        chk("timeout_restart_cnt_lit", DIGIT_COUNT, 2);
        idle(1);
        chk("timeout_restart_pulse_lit", CANCEL, 1);

        // Reset mid-entry, leaving reset with MODE=1
        key(1); key(2);
        cycle(1, 1, 0, 0);
        chk("reset_mid_lit", {PIN0, PIN1, DIGIT_COUNT}, 0);
        cur_mode = 1;
        key(7);
        chk("reset_exit_mode_lit", DIGIT_COUNT, 0);

        // Randomized traffic with varying key density
        dens = 50;
        for (int c = 0; c < 4000; c++) begin
            if (c % 200 == 0) dens = $urandom_range(5, 95);
            if ($urandom_range(0, 99) == 0) cur_mode = ~cur_mode;
            if ($urandom_range(0, 9) < 6) kc = 4'($urandom_range(0, 9));
            else                          kc = 4'($urandom_range(10, 15));
            if ($urandom_range(0, 299) == 0)
                cycle(1, cur_mode, 1'($urandom_range(0, 1)), kc);
            else
                cycle(0, cur_mode, ($urandom_range(0, 99) < dens), kc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
